pipe_front_regs: RTL and testbench
==================================

Name: pipe_front_regs

Overview:
- Fetch-side program counter plus the instruction/PC pipeline registers that feed the pipelined controller's X, M and W stage inputs.
- Owns PC sequencing (PC+4 or redirect), load-use stall hold, bubble insertion, and squash of the wrong-path fetch after a taken branch/jump.
- Sits between the instruction memory (combinational read of pc_f) and the execute/memory/writeback datapath and controller.
- Tracks per-stage valid bits and a retired-instruction counter for debug and verification.

Parameters:
- AWIDTH, 32, PC/address width.
- DWIDTH, 32, instruction/data width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP, 32'h0000_0013, encoding injected as a bubble (addi x0,x0,0).
- CWIDTH, 32, retired-instruction counter width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- inst_f  input  DWIDTH  instruction read from imem at pc_f (same cycle)
- alu_out  input  DWIDTH  branch/jump target computed in X
- PCSel  input  1  redirect request from X (taken branch or jump)
- stall  input  1  load-use stall request
- flush  input  1  external squash of the instruction entering X
- pc_f  output  AWIDTH  fetch PC / imem address
- pc_x, pc_m, pc_w  output  AWIDTH  PC of the instruction in X/M/W
- pc4_w  output  AWIDTH  pc_w+4, the link value for writeback
- inst_x, inst_m, inst_w  output  DWIDTH  instruction registers for X/M/W
- valid_x, valid_m, valid_w  output  1  stage holds a real (non-bubble) instruction
- instret  output  CWIDTH  count of instructions retired from W

Behaviour:
- Reset (async, immediate):
  - pc_f=RESET_PC.
  - inst_x/m/w=NOP; pc_x/m/w=0; valid_x/m/w=0; instret=0.
  - pc4_w=4 (combinational from pc_w).
- Internal controls:
  - kill = (PCSel | flush) & ~stall.
  - stall has priority over PCSel and flush.
- Normal cycle (stall=0, kill=0):
  - pc_f<=pc_f+4.
  - X<=(inst_f, pc_f, valid 1).
  - M<=X, W<=M; inst, pc and valid move together.
- Stall cycle (stall=1):
  - pc_f held; X held (inst, pc, valid).
  - M<=(NOP, pc 0, valid 0).
  - W<=M.
  - PCSel and flush are ignored this cycle; the controller re-evaluates them next cycle.
- Kill cycle (kill=1):
  - X<=(NOP, pc 0, valid 0), squashing the wrong-path fetch.
  - M<=X: the branch/jump itself proceeds. W<=M.
  - pc_f update:
    - PCSel=1: pc_f<={alu_out[AWIDTH-1:1],1'b0} (bit 0 cleared, per JALR).
    - PCSel=0 (flush only): pc_f<=pc_f+4.
- PC arithmetic: pc_f+4 wraps modulo 2^AWIDTH with no fault. pc4_w wraps the same way.
- instret:
  - Increments by 1 on each rising edge where valid_w=1.
  - Wraps to 0 after all-ones.
  - Not affected by stall or kill directly; it only counts W.
- Latency:
  - An instruction fetched at edge n appears in X after edge n+1, M after n+2, W after n+3, absent stalls.
  - Each stall adds one cycle; each kill removes exactly one instruction (the one in F).
- Consecutive stalls: X holds for every stalled cycle, and one bubble enters M per stalled cycle.
- Consecutive kills (e.g. back-to-back jumps): each cycle independently squashes the F instruction.
- Reset mid-operation: all state returns to reset values asynchronously, with no partial stage update. Fetch restarts at RESET_PC on the first edge after rst falls.
- All outputs are driven directly from registers except pc4_w.

Test Plan:
- Reset then free-run 6 cycles, inst_f=PC-indexed ROM:
  - pc_f sequence is 0,4,8,12,16,20.
  - inst_w equals ROM[0] on cycle 4; instret=3 after cycle 6.
- stall=1 for one cycle while X holds the lw consumer at pc 8:
  - pc_f stays 12 for two cycles; inst_x stays ROM[2].
  - inst_m=NOP, valid_m=0 for one cycle; no instruction is lost or duplicated in W.
- PCSel=1 with alu_out=32'h0000_0041 while X holds the branch at pc 16:
  - next pc_f=32'h40; inst_x=NOP, valid_x=0.
  - inst_m is the branch, pc_m=16.
- stall=1 and PCSel=1 in the same cycle:
  - stall wins: pc_f held, X held, bubble in M, no redirect.
- flush=1 alone at pc_f=24:
  - pc_f=28; X is a bubble; the instruction at 24 never reaches W and instret does not count it.
- Assert rst mid-stream with valid_w=1:
  - outputs go to reset values immediately and instret=0.
  - Fetch restarts at RESET_PC; pc_f=32'hFFFF_FFFC followed by +4 wraps to 0.

Source files
------------

// File: rtl/pipe_front_regs_if.sv
// Fetch/pipeline-register bundle: imem and X-stage controls in, stage registers out.
// The master side drives fetch data and controls; the slave side is the pipe_front_regs block.
interface pipe_front_regs_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 32
);
    logic [DWIDTH-1:0] inst_f;
    logic [DWIDTH-1:0] alu_out;
    logic              PCSel;
    logic              stall;
    logic              flush;
    logic [AWIDTH-1:0] pc_f;
    logic [AWIDTH-1:0] pc_x;
    logic [AWIDTH-1:0] pc_m;
    logic [AWIDTH-1:0] pc_w;
    logic [AWIDTH-1:0] pc4_w;
    logic [DWIDTH-1:0] inst_x;
    logic [DWIDTH-1:0] inst_m;
    logic [DWIDTH-1:0] inst_w;
    logic              valid_x;
    logic              valid_m;
    logic              valid_w;
    logic [CWIDTH-1:0] instret;

    modport master (
        output inst_f, alu_out, PCSel, stall, flush,
        input  pc_f, pc_x, pc_m, pc_w, pc4_w,
        input  inst_x, inst_m, inst_w,
        input  valid_x, valid_m, valid_w, instret
    );

    modport slave (
        input  inst_f, alu_out, PCSel, stall, flush,
        output pc_f, pc_x, pc_m, pc_w, pc4_w,
        output inst_x, inst_m, inst_w,
        output valid_x, valid_m, valid_w, instret
    );
endinterface

// File: rtl/pipe_front_regs.sv
// Fetch PC and X/M/W instruction/PC pipeline registers with stall, bubble and
// wrong-path squash handling, plus a retired-instruction counter.
module pipe_front_regs #(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] RESET_PC = '0,
    parameter logic [DWIDTH-1:0] NOP      = 32'h0000_0013,
    parameter int                CWIDTH   = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_front_regs_if.slave bus
);

    logic [AWIDTH-1:0] pc_f_q, pc_f_d;
    logic [AWIDTH-1:0] pc_x_q, pc_x_d;
    logic [AWIDTH-1:0] pc_m_q, pc_m_d;
    logic [AWIDTH-1:0] pc_w_q, pc_w_d;
    logic [DWIDTH-1:0] inst_x_q, inst_x_d;
    logic [DWIDTH-1:0] inst_m_q, inst_m_d;
    logic [DWIDTH-1:0] inst_w_q, inst_w_d;
    logic              valid_x_q, valid_x_d;
    logic              valid_m_q, valid_m_d;
    logic              valid_w_q, valid_w_d;
    logic [CWIDTH-1:0] instret_q, instret_d;

    logic              kill;
    logic [DWIDTH-1:0] target;
    logic [AWIDTH-1:0] pc_plus4;

    // stall outranks any redirect or squash; the controller re-raises them later
    assign kill     = (bus.PCSel | bus.flush) & ~bus.stall;
    assign target   = bus.alu_out & ~DWIDTH'(1);
    assign pc_plus4 = pc_f_q + AWIDTH'(4);

    always_comb begin
        pc_f_d    = pc_plus4;
        pc_x_d    = pc_f_q;
        inst_x_d  = bus.inst_f;
        valid_x_d = 1'b1;
        pc_m_d    = pc_x_q;
        inst_m_d  = inst_x_q;
        valid_m_d = valid_x_q;
        pc_w_d    = pc_m_q;
        inst_w_d  = inst_m_q;
        valid_w_d = valid_m_q;
        instret_d = instret_q + (valid_w_q ? CWIDTH'(1) : CWIDTH'(0));

        if (bus.stall) begin
            pc_f_d    = pc_f_q;
            pc_x_d    = pc_x_q;
            inst_x_d  = inst_x_q;
            valid_x_d = valid_x_q;
            pc_m_d    = '0;
            inst_m_d  = NOP;
            valid_m_d = 1'b0;
        end else if (kill) begin
            pc_x_d    = '0;
            inst_x_d  = NOP;
            valid_x_d = 1'b0;
            if (bus.PCSel) begin
                pc_f_d = target[AWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_f_q    <= RESET_PC;
            pc_x_q    <= '0;
            pc_m_q    <= '0;
            pc_w_q    <= '0;
            inst_x_q  <= NOP;
            inst_m_q  <= NOP;
            inst_w_q  <= NOP;
            valid_x_q <= 1'b0;
            valid_m_q <= 1'b0;
            valid_w_q <= 1'b0;
            instret_q <= '0;
        end else begin
            pc_f_q    <= pc_f_d;
            pc_x_q    <= pc_x_d;
            pc_m_q    <= pc_m_d;
            pc_w_q    <= pc_w_d;
            inst_x_q  <= inst_x_d;
            inst_m_q  <= inst_m_d;
            inst_w_q  <= inst_w_d;
            valid_x_q <= valid_x_d;
            valid_m_q <= valid_m_d;
            valid_w_q <= valid_w_d;
            instret_q <= instret_d;
        end
    end

    assign bus.pc_f    = pc_f_q;
    assign bus.pc_x    = pc_x_q;
    assign bus.pc_m    = pc_m_q;
    assign bus.pc_w    = pc_w_q;
    assign bus.pc4_w   = pc_w_q + AWIDTH'(4);
    assign bus.inst_x  = inst_x_q;
    assign bus.inst_m  = inst_m_q;
    assign bus.inst_w  = inst_w_q;
    assign bus.valid_x = valid_x_q;
    assign bus.valid_m = valid_m_q;
    assign bus.valid_w = valid_w_q;
    assign bus.instret = instret_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench for pipe_front_regs: directed hazards, random traffic and
// async reset, compared against a stage-record reference model.
module tb_pipe_front_regs;

    localparam logic [31:0] NOP_C = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        v;
    } stg_t;

    localparam stg_t BUBBLE = '{inst: NOP_C, pc: 32'h0, v: 1'b0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    stg_t        mx, mm, mw;
    logic [31:0] mpc, mret;

    pipe_front_regs_if #(.AWIDTH(32), .DWIDTH(32), .CWIDTH(32)) bus ();

    pipe_front_regs #(
        .AWIDTH(32), .DWIDTH(32), .RESET_PC(32'h0), .NOP(NOP_C), .CWIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A3C_0F01;
    endfunction

    assign bus.inst_f = rom(bus.pc_f);

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = BUBBLE; mm = BUBBLE; mw = BUBBLE;
        mpc = 32'h0; mret = 32'h0;
    endtask

    // One clock edge of the fetch/pipe rules applied to the stage records
    task automatic model_edge(input logic st, input logic ps, input logic fl, input logic [31:0] alu);
        stg_t nx, nm, nw;
        logic [31:0] npc;
        nw = mm;
        mret = mret + (mw.v ? 32'd1 : 32'd0);
        if (st) begin
            nx = mx; nm = BUBBLE; npc = mpc;
        end else if (ps || fl) begin
            nx = BUBBLE; nm = mx;
            npc = ps ? {alu[31:1], 1'b0} : mpc + 32'd4;
        end else begin
            nx = '{inst: rom(mpc), pc: mpc, v: 1'b1}; nm = mx; npc = mpc + 32'd4;
        end
        mx = nx; mm = nm; mw = nw; mpc = npc;
    endtask

    task automatic check_all();
        cmp("pc_f", bus.pc_f, mpc);
        cmp("pc_x", bus.pc_x, mx.pc);
        cmp("pc_m", bus.pc_m, mm.pc);
        cmp("pc_w", bus.pc_w, mw.pc);
        cmp("pc4_w", bus.pc4_w, mw.pc + 32'd4);
        cmp("inst_x", bus.inst_x, mx.inst);
        cmp("inst_m", bus.inst_m, mm.inst);
        cmp("inst_w", bus.inst_w, mw.inst);
        cmp("valid_x", {31'b0, bus.valid_x}, {31'b0, mx.v});
        cmp("valid_m", {31'b0, bus.valid_m}, {31'b0, mm.v});
        cmp("valid_w", {31'b0, bus.valid_w}, {31'b0, mw.v});
        cmp("instret", bus.instret, mret);
    endtask

    task automatic step(input logic st, input logic ps, input logic fl, input logic [31:0] alu);
        bus.stall = st; bus.PCSel = ps; bus.flush = fl; bus.alu_out = alu;
        @(posedge clk);
        model_edge(st, ps, fl, alu);
        #1;
        check_all();
    endtask

    initial begin
        bus.stall = 1'b0; bus.PCSel = 1'b0; bus.flush = 1'b0; bus.alu_out = 32'h0;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Free run: pc_f 4..24, first instruction in W after edge 3
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        cmp("instret_after6", bus.instret, 32'd3);

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        step(1'b0, 1'b1, 1'b0, 32'h0000_0041);
        cmp("redirect_pc", bus.pc_f, 32'h0000_0040);
        step(1'b0, 1'b0, 1'b0, 32'h0);

        step(1'b1, 1'b1, 1'b0, 32'h0000_0100);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0000_0200);
        step(1'b0, 1'b1, 1'b0, 32'h0000_0301);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0080);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, $urandom);
        end

        // Async reset between edges while W holds real work
        while (!bus.valid_w) step(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        cmp("instret_rst", bus.instret, 32'h0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap: redirect to the top of the address space and run through W
        step(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFD);
        cmp("wrap_top", bus.pc_f, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        cmp("wrap_zero", bus.pc_f, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
